// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter and its sequence checker.
package johnson_pkg;

  localparam int JOHNSON_WIDTH = 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  function automatic int unsigned phase_step(input int unsigned phase,
                                             input int unsigned prev,
                                             input int unsigned seq_len);
    return (phase + seq_len - prev) % seq_len;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code check and phase decode.
// Legal codes have their ones packed at the LSB end or at the MSB end.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = JOHNSON_WIDTH,
  parameter int PH_W  = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_legal,
  output logic [PH_W-1:0]  o_phase
);

  logic [WIDTH-1:0] w_inv;
  logic [WIDTH-1:0] w_lo_chk;
  logic [WIDTH-1:0] w_hi_chk;
  logic [PH_W-1:0]  w_ones;

  assign w_inv    = ~i_code;
  assign w_lo_chk = i_code & (i_code + WIDTH'(1));
  assign w_hi_chk = w_inv & (w_inv + WIDTH'(1));
  assign o_legal  = (w_lo_chk == '0) || (w_hi_chk == '0);

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + PH_W'(i_code[i]);
    end
  end

  // 2*WIDTH may truncate to 0 in PH_W bits; the modular subtraction still yields 2*WIDTH-popcount.
  assign o_phase = i_code[WIDTH-1] ? (PH_W'(2*WIDTH) - w_ones) : w_ones;

endmodule

// File: rtl/johnson_seq_checker.sv
// Checks a Johnson counter stream: legality, step-by-one sequencing, lock state,
// revolution and error counts. All outputs are registered, one cycle after the sample.
module johnson_seq_checker
  import johnson_pkg::*;
#(
  parameter  int WIDTH      = JOHNSON_WIDTH,
  parameter  int LOCK_COUNT = 4,
  parameter  int CNT_W      = 16,
  localparam int PH_W       = $clog2(2*WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  johnson_in,
  input  logic              clear,
  output logic [PH_W-1:0]   phase_out,
  output logic              phase_valid,
  output logic              illegal_code,
  output logic              bad_step,
  output logic              locked,
  output logic [CNT_W-1:0]  rev_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky
);

  localparam int unsigned SEQ_LEN = 2 * WIDTH;
  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GC_W-1:0] LOCK_LAST = GC_W'(LOCK_COUNT - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SEQ_LEN - 1);

  logic              w_legal;
  logic [PH_W-1:0]   w_phase;
  int unsigned       w_step;
  logic              w_checking;
  logic              w_good;
  logic              w_bad;
  logic              w_err;
  logic              w_rev;
  lock_state_t       w_state_nxt;
  logic [GC_W-1:0]   w_good_nxt;

  lock_state_t       r_state;
  logic [GC_W-1:0]   r_good;
  logic [PH_W-1:0]   r_prev;
  logic [PH_W-1:0]   r_phase;
  logic              r_phase_valid;
  logic              r_illegal;
  logic              r_bad;
  logic              r_locked;
  logic [CNT_W-1:0]  r_rev;
  logic [CNT_W-1:0]  r_err;
  logic              r_sticky;

  johnson_code_decode #(.WIDTH(WIDTH), .PH_W(PH_W)) u_decode (
    .i_code  (johnson_in),
    .o_legal (w_legal),
    .o_phase (w_phase)
  );

  assign w_step     = phase_step(32'(w_phase), 32'(r_prev), SEQ_LEN);
  // In UNLOCKED the sample only establishes the reference; no step is judged.
  assign w_checking = (r_state != UNLOCKED);
  assign w_good     = in_valid && w_legal && w_checking && (w_step == 32'd1);
  assign w_bad      = in_valid && w_legal && w_checking && (w_step > 32'd1);
  assign w_err      = (in_valid && !w_legal) || w_bad;
  assign w_rev      = w_good && (r_prev == PH_LAST) && (w_phase == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (clear) begin
      w_state_nxt = UNLOCKED;
      w_good_nxt  = '0;
    end else if (in_valid) begin
      if (!w_legal) begin
        w_state_nxt = UNLOCKED;
        w_good_nxt  = '0;
      end else begin
        case (r_state)
          UNLOCKED: begin
            w_state_nxt = ACQUIRE;
            w_good_nxt  = '0;
          end
          ACQUIRE: begin
            if (w_bad) begin
              w_good_nxt = '0;
            end else if (w_good) begin
              if (r_good == LOCK_LAST) begin
                w_state_nxt = LOCKED;
                w_good_nxt  = '0;
              end else begin
                w_good_nxt = r_good + GC_W'(1);
              end
            end
          end
          LOCKED: begin
            if (w_bad) begin
              w_state_nxt = ACQUIRE;
              w_good_nxt  = '0;
            end
          end
          default: begin
            w_state_nxt = UNLOCKED;
            w_good_nxt  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= UNLOCKED;
      r_good        <= '0;
      r_prev        <= '0;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_illegal     <= 1'b0;
      r_bad         <= 1'b0;
      r_locked      <= 1'b0;
      r_rev         <= '0;
      r_err         <= '0;
      r_sticky      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_good        <= w_good_nxt;
      r_locked      <= (w_state_nxt == LOCKED);
      r_phase_valid <= in_valid && w_legal;
      r_illegal     <= in_valid && !w_legal;
      r_bad         <= w_bad;
      if (in_valid && w_legal) begin
        r_phase <= w_phase;
        r_prev  <= w_phase;
      end
      if (clear) begin
        r_rev    <= '0;
        r_err    <= '0;
        r_sticky <= 1'b0;
      end else begin
        if (w_err) begin
          r_sticky <= 1'b1;
          if (r_err != '1) r_err <= r_err + CNT_W'(1);
        end
        if (w_rev) r_rev <= r_rev + CNT_W'(1);
      end
    end
  end

  assign phase_out    = r_phase;
  assign phase_valid  = r_phase_valid;
  assign illegal_code = r_illegal;
  assign bad_step     = r_bad;
  assign locked       = r_locked;
  assign rev_count    = r_rev;
  assign err_count    = r_err;
  assign err_sticky   = r_sticky;

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Directed bench for johnson_seq_checker: main instance (CNT_W=16) plus a CNT_W=4 instance for saturation.
module tb_johnson_seq_checker;
  import johnson_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  johnson_in = '0;
  logic        clear = 1'b0;
  logic [2:0]  phase_out;
  logic        phase_valid, illegal_code, bad_step, locked, err_sticky;
  logic [15:0] rev_count, err_count;

  logic        s_valid = 1'b0;
  logic [3:0]  s_code = '0;
  logic        s_clear = 1'b0;
  logic [2:0]  s_phase_out;
  logic        s_phase_valid, s_illegal, s_bad, s_locked, s_sticky;
  logic [3:0]  s_rev, s_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_seq_checker #(.WIDTH(4), .LOCK_COUNT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .johnson_in(johnson_in), .clear(clear),
    .phase_out(phase_out), .phase_valid(phase_valid), .illegal_code(illegal_code),
    .bad_step(bad_step), .locked(locked), .rev_count(rev_count), .err_count(err_count),
    .err_sticky(err_sticky)
  );

  johnson_seq_checker #(.WIDTH(4), .LOCK_COUNT(4), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_valid), .johnson_in(s_code), .clear(s_clear),
    .phase_out(s_phase_out), .phase_valid(s_phase_valid), .illegal_code(s_illegal),
    .bad_step(s_bad), .locked(s_locked), .rev_count(s_rev), .err_count(s_err),
    .err_sticky(s_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] code);
    in_valid = v;
    johnson_in = code;
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic [3:0] code, input logic clr);
    s_valid = 1'b1;
    s_code = code;
    s_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, 32'(phase_out), 0);
    chk({tag, "_pv"}, 32'(phase_valid), 0);
    chk({tag, "_ill"}, 32'(illegal_code), 0);
    chk({tag, "_bad"}, 32'(bad_step), 0);
    chk({tag, "_lock"}, 32'(locked), 0);
    chk({tag, "_rev"}, 32'(rev_count), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_sticky"}, 32'(err_sticky), 0);
  endtask

  initial begin
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Two revolutions: reference + 4 good steps locks on the 5th sample.
    for (int n = 0; n < 16; n++) begin
      step(1'b1, seq[n % 8]);
      chk("t1_phase", 32'(phase_out), n % 8);
      chk("t1_pv", 32'(phase_valid), 1);
      chk("t1_lock", 32'(locked), (n >= 4) ? 1 : 0);
    end
    chk("t1_rev", 32'(rev_count), 1);
    chk("t1_err", 32'(err_count), 0);
    chk("t1_sticky", 32'(err_sticky), 0);

    // Illegal code while locked.
    step(1'b1, 4'b0101);
    chk("t2_ill", 32'(illegal_code), 1);
    chk("t2_pv", 32'(phase_valid), 0);
    chk("t2_err", 32'(err_count), 1);
    chk("t2_sticky", 32'(err_sticky), 1);
    chk("t2_lock", 32'(locked), 0);
    chk("t2_phase", 32'(phase_out), 7);

    // Re-acquire through a wrap in ACQUIRE: 6 ref, 7, 0 (rev), 1, 2 -> locked at phase 2.
    step(1'b1, 4'b1100);
    chk("t2_ref_bad", 32'(bad_step), 0);
    step(1'b1, 4'b1000);
    step(1'b1, 4'b0000);
    chk("t2_rev_acq", 32'(rev_count), 2);
    step(1'b1, 4'b0001);
    chk("t2_lock_pre", 32'(locked), 0);
    step(1'b1, 4'b0011);
    chk("t2_relock", 32'(locked), 1);

    // Bad step 2 -> 5 while locked.
    step(1'b1, 4'b1110);
    chk("t3_bad", 32'(bad_step), 1);
    chk("t3_pv", 32'(phase_valid), 1);
    chk("t3_phase", 32'(phase_out), 5);
    chk("t3_err", 32'(err_count), 2);
    chk("t3_lock", 32'(locked), 0);
    step(1'b1, 4'b1100); chk("t3_lock_g1", 32'(locked), 0);
    step(1'b1, 4'b1000); chk("t3_lock_g2", 32'(locked), 0);
    step(1'b1, 4'b0000); chk("t3_lock_g3", 32'(locked), 0);
    chk("t3_rev", 32'(rev_count), 3);
    step(1'b1, 4'b0001); chk("t3_lock_g4", 32'(locked), 1);

    // Hold at phase 3 for 10 cycles.
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0111);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0111);
      chk("t4_pv", 32'(phase_valid), 1);
      chk("t4_phase", 32'(phase_out), 3);
      chk("t4_lock", 32'(locked), 1);
      chk("t4_bad", 32'(bad_step), 0);
    end
    chk("t4_err", 32'(err_count), 2);
    step(1'b0, 4'b0101);
    chk("t4_idle_pv", 32'(phase_valid), 0);
    chk("t4_idle_ill", 32'(illegal_code), 0);
    chk("t4_idle_err", 32'(err_count), 2);
    chk("t4_idle_phase", 32'(phase_out), 3);

    // Saturation on the CNT_W=4 instance.
    for (int i = 1; i <= 20; i++) begin
      sstep((i % 2 == 1) ? 4'b0101 : 4'b1010, 1'b0);
      chk("t5_err", 32'(s_err), (i > 15) ? 15 : i);
      chk("t5_ill", 32'(s_illegal), 1);
    end
    chk("t5_sticky", 32'(s_sticky), 1);
    sstep(4'b1001, 1'b1);
    chk("t5_clr_ill", 32'(s_illegal), 1);
    chk("t5_clr_err", 32'(s_err), 0);
    chk("t5_clr_sticky", 32'(s_sticky), 0);
    sstep(4'b0000, 1'b0);
    chk("t5_post_pv", 32'(s_phase_valid), 1);
    chk("t5_post_err", 32'(s_err), 0);
    s_valid = 1'b0;

    // Asynchronous reset between clock edges.
    step(1'b1, 4'b1111);
    chk("t6_pre_lock", 32'(locked), 1);
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 4'b0011);
    chk("t6_pv", 32'(phase_valid), 1);
    chk("t6_bad", 32'(bad_step), 0);
    chk("t6_err", 32'(err_count), 0);
    chk("t6_lock", 32'(locked), 0);
    step(1'b1, 4'b0111);
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1110);
    chk("t6_lock_pre", 32'(locked), 0);
    step(1'b1, 4'b1100);
    chk("t6_relock", 32'(locked), 1);
    chk("t6_sticky", 32'(err_sticky), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
